// File: rtl/rockwave_pkg.sv
// Shared RockWave core constants: datapath width, reset values, fetch FSM encoding.
// Single-cycle helpers only; no state lives here.
package rockwave_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  localparam logic FETCH_IDLE = 1'b0;
  localparam logic FETCH_REQ  = 1'b1;

  localparam int PC_INC = 4;

  // Instruction targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with sequential/jump next-PC selection and misaligned-target flag.
// Updates one cycle after i_upd; a misaligned jump leaves the PC untouched.
module fetch_pc_reg #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_upd,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_fetch_err
);
  import rockwave_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic            r_fetch_err;
  logic            w_bad_target;

  assign w_bad_target = i_jump_en && is_misaligned(i_jump_addr[1:0]);

  // Sequential increment wraps naturally at 2^XLEN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_VECTOR;
      r_fetch_err <= 1'b0;
    end else if (i_upd) begin
      if (w_bad_target) begin
        r_fetch_err <= 1'b1;
      end else if (i_jump_en) begin
        r_pc        <= i_jump_addr;
        r_fetch_err <= 1'b0;
      end else begin
        r_pc        <= r_pc + XLEN'(PC_INC);
        r_fetch_err <= 1'b0;
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_fetch_err = r_fetch_err;

endmodule

// File: rtl/fetch_unit.sv
// RockWave instruction fetch: owns the PC, runs the imem req/ack handshake, latches inst for decode.
// Request issues the cycle after FETCH; stall_fetch drops combinationally in the ack cycle.
module fetch_unit #(
  parameter int               XLEN         = rockwave_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = rockwave_pkg::RESET_VECTOR,
  parameter logic [XLEN-1:0]  INST_NOP     = rockwave_pkg::INST_NOP
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_phase_fetch,
  input  logic            i_phase_writeback,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic            o_stall_fetch,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_fetch_err
);
  import rockwave_pkg::*;

  logic            r_state;
  logic            w_next_state;
  logic            w_ack_take;
  logic            w_pc_upd;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= FETCH_IDLE;
    else          r_state <= w_next_state;
  end

  // Writeback wins over fetch when both phases are asserted.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH_IDLE: if (i_phase_fetch && !i_phase_writeback) w_next_state = FETCH_REQ;
      FETCH_REQ:  if (i_imem_ack)                          w_next_state = FETCH_IDLE;
      default:                                             w_next_state = FETCH_IDLE;
    endcase
  end

  always_comb begin
    w_ack_take    = (r_state == FETCH_REQ) && i_imem_ack;
    w_pc_upd      = i_phase_writeback && (r_state == FETCH_IDLE);
    o_stall_fetch = i_phase_fetch && !w_ack_take;
  end

  // The state flop doubles as the registered request.
  assign o_imem_req  = r_state;
  assign o_imem_addr = w_pc;

  fetch_pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_upd       (w_pc_upd),
    .i_jump_en   (i_jump_en),
    .i_jump_addr (i_jump_addr),
    .o_pc        (w_pc),
    .o_fetch_err (o_fetch_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inst    <= INST_NOP;
      r_inst_pc <= RESET_VECTOR;
    end else if (w_ack_take) begin
      r_inst    <= i_imem_rdata;
      r_inst_pc <= w_pc;
    end
  end

  assign o_inst    = r_inst;
  assign o_inst_pc = r_inst_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch results queued at issue, compared by a monitor on handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phase_fetch, phase_writeback, jump_en, imem_ack;
  logic [31:0] jump_addr, imem_rdata;
  logic        stall_fetch, imem_req, fetch_err;
  logic [31:0] imem_addr, inst, inst_pc;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_phase_fetch     (phase_fetch),
    .i_phase_writeback (phase_writeback),
    .i_jump_en         (jump_en),
    .i_jump_addr       (jump_addr),
    .o_stall_fetch     (stall_fetch),
    .o_imem_req        (imem_req),
    .o_imem_addr       (imem_addr),
    .i_imem_ack        (imem_ack),
    .i_imem_rdata      (imem_rdata),
    .o_inst            (inst),
    .o_inst_pc         (inst_pc),
    .o_fetch_err       (fetch_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake seen mid-cycle retires the oldest expected fetch after the edge.
  always @(negedge clk) begin
    #3;
    if (imem_req && imem_ack) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_inst_pc", inst_pc, e.pc);
      end
    end
  end

  // One fetch: FETCH asserted, then wait_n cycles without ack, then ack with rdata.
  task automatic do_fetch(input int wait_n, input logic [31:0] rdata, input logic [31:0] exp_pc);
    exp_t e;
    @(negedge clk);
    phase_fetch = 1'b1;
    #1;
    chk("stall_first", {31'd0, stall_fetch}, 32'd1);
    chk("req_first", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      #1;
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_stall", {31'd0, stall_fetch}, 32'd1);
    end
    @(negedge clk);
    e.inst = rdata;
    e.pc   = exp_pc;
    exp_q.push_back(e);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    #1;
    chk("ack_req", {31'd0, imem_req}, 32'd1);
    chk("ack_addr", imem_addr, exp_pc);
    chk("ack_stall", {31'd0, stall_fetch}, 32'd0);
    @(negedge clk);
    imem_ack    = 1'b0;
    phase_fetch = 1'b0;
    #1;
    chk("post_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_wb(input logic jen, input logic [31:0] jaddr,
                       input logic [31:0] exp_pc, input logic exp_err);
    @(negedge clk);
    phase_writeback = 1'b1;
    jump_en         = jen;
    jump_addr       = jaddr;
    @(negedge clk);
    phase_writeback = 1'b0;
    jump_en         = 1'b0;
    #1;
    chk("wb_pc", imem_addr, exp_pc);
    chk("wb_err", {31'd0, fetch_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0; phase_fetch = 1'b0; phase_writeback = 1'b0; jump_en = 1'b0;
    jump_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_stall", {31'd0, stall_fetch}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_fetch(0, 32'h0050_0093, 32'h0);
    do_fetch(3, 32'h00A0_0113, 32'h0);

    do_wb(1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0);
    do_wb(1'b0, 32'h0,         32'h0000_0104, 1'b0);
    do_wb(1'b1, 32'h0000_2000, 32'h0000_2000, 1'b0);
    do_fetch(1, 32'h1234_5678, 32'h0000_2000);
    do_wb(1'b1, 32'h0000_2002, 32'h0000_2000, 1'b1);
    do_wb(1'b0, 32'h0,         32'h0000_2004, 1'b0);
    do_wb(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    do_wb(1'b0, 32'h0,         32'h0000_0000, 1'b0);
    do_wb(1'b1, 32'h0000_0001, 32'h0000_0000, 1'b1);

    // Both phases high: PC advances, no request is raised.
    @(negedge clk);
    phase_fetch = 1'b1; phase_writeback = 1'b1;
    @(negedge clk);
    phase_fetch = 1'b0; phase_writeback = 1'b0;
    #1;
    chk("both_req", {31'd0, imem_req}, 32'd0);
    chk("both_pc", imem_addr, 32'h0000_0004);
    chk("both_err", {31'd0, fetch_err}, 32'd0);

    // Asynchronous reset in the middle of an outstanding request.
    @(negedge clk);
    phase_fetch = 1'b1;
    @(negedge clk);
    phase_fetch = 1'b0;
    #1;
    chk("midreq_req", {31'd0, imem_req}, 32'd1);
    chk("midreq_addr", imem_addr, 32'h0000_0004);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", imem_addr, 32'h0);
    chk("arst_inst", inst, 32'h0000_0013);
    chk("arst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("idle_ack_inst", inst, 32'h0000_0013);
    chk("idle_ack_req", {31'd0, imem_req}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RockWave core; directly upstream of the phase sequencer.
- Consumes phase_fetch and phase_writeback from the sequencer. Returns stall_fetch to hold the FETCH phase while instruction memory is busy.
- Owns the program counter, runs a req/ack handshake with instruction memory, and presents the latched instruction and its PC to decode.

Parameters:
- XLEN, 32, data/address width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- INST_NOP, 32'h0000_0013, instruction register value after reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- phase_fetch  in  1  FETCH phase active.
- phase_writeback  in  1  WRITEBACK phase active; PC update point.
- jump_en  in  1  taken branch/jump, sampled with phase_writeback.
- jump_addr  in  XLEN  branch/jump target.
- stall_fetch  out  1  hold FETCH phase (combinational).
- imem_req  out  1  fetch request, registered.
- imem_addr  out  XLEN  fetch address, equals pc while imem_req.
- imem_ack  in  1  memory ack; imem_rdata valid this cycle.
- imem_rdata  in  XLEN  fetched instruction word.
- inst  out  XLEN  latched instruction to decode.
- inst_pc  out  XLEN  PC of inst.
- fetch_err  out  1  misaligned jump target flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, inst=INST_NOP, inst_pc=RESET_VECTOR.
  - imem_req=0, fetch_err=0, state=IDLE.
  - Takes effect immediately, including mid-transaction. An ack arriving after reset while IDLE is ignored.
- FSM states: IDLE, REQ.
  - IDLE -> REQ when phase_fetch=1 and phase_writeback=0. imem_req=1 from the next cycle.
  - REQ: imem_req held at 1 and imem_addr held at pc until imem_ack=1. Ack cycle: inst<=imem_rdata, inst_pc<=pc, imem_req<=0, state<=IDLE.
  - imem_ack while IDLE has no effect.
- stall_fetch = phase_fetch AND NOT(state==REQ AND imem_ack). Fastest fetch:
  - cycle N phase_fetch, stall=1;
  - cycle N+1 req=1, ack=1, stall=0;
  - inst valid from N+2.
- PC update happens only in a cycle with phase_writeback=1 and state==IDLE:
  - jump_en=0: pc<=pc+4, modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), fetch_err<=0.
  - jump_en=1 and jump_addr[1:0]==0: pc<=jump_addr, fetch_err<=0.
  - jump_en=1 and jump_addr[1:0]!=0: pc unchanged, fetch_err<=1. fetch_err holds until the next successful PC update or reset.
- phase_fetch and phase_writeback both high (illegal): the PC update takes precedence and no request is issued that cycle.
- phase_fetch dropping while in REQ: the request still completes; inst is updated on ack.
- imem_addr = pc at all times. Only imem_req qualifies it.

Decomposition:
- Shared package rockwave_pkg holds:
  - XLEN, RESET_VECTOR, INST_NOP.
  - FSM state localparams FETCH_IDLE=1'b0, FETCH_REQ=1'b1.
  - PC_INC=4.
- One natural sub-module, fetch_pc_reg: the PC register plus next-PC/misalign logic and fetch_err. The handshake FSM and instruction register stay in fetch_unit.

Test Plan:
- Reset: rst_n=0 asynchronously mid-REQ -> imem_req=0 immediately, pc=0x0, inst=0x00000013. A later ack with rdata=0xDEADBEEF leaves inst unchanged.
- Zero-wait fetch: pc=0x0, phase_fetch at N, ack at N+1 with rdata=0x00500093:
  - stall_fetch is 1,0 at cycles N,N+1;
  - inst=0x00500093 and inst_pc=0x0 at N+2.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr=0x0 stable for all 4 cycles, stall_fetch=1 until the ack cycle.
- Sequential and wrap-around:
  - phase_writeback with jump_en=0 at pc=0x100 -> pc=0x104;
  - at pc=0xFFFFFFFC -> pc=0x0.
- Jump: jump_en=1, jump_addr=0x2000 -> next imem_addr=0x2000, fetch_err=0.
- Misaligned jump: jump_addr=0x2002 -> pc unchanged, fetch_err=1. A following sequential writeback -> pc+4, fetch_err=0.
